// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcode values, immediate formats and
// the per-opcode control summary used by the decode stage.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_t;

  // What an opcode needs from the rest of the stage.
  typedef struct packed {
    logic     rs1_used;
    logic     rs2_used;
    logic     rd_we;
    logic     illegal;
    imm_fmt_t fmt;
  } dec_ctrl_t;

  // Contents of the decode->execute output register.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        illegal;
  } ex_reg_t;

  // Operand usage, write enable and immediate format for one opcode.
  // Writes to x0 are dropped here so nothing downstream scoreboards x0.
  function automatic dec_ctrl_t decode_ctrl(input logic [6:0] opcode,
                                            input logic [4:0] rd);
    dec_ctrl_t c;
    logic      we_raw;
    c        = '{rs1_used: 1'b0, rs2_used: 1'b0, rd_we: 1'b0,
                 illegal: 1'b0, fmt: IMM_NONE};
    we_raw   = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        c.fmt  = IMM_U;
        we_raw = 1'b1;
      end
      OPC_JAL: begin
        c.fmt  = IMM_J;
        we_raw = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        c.rs1_used = 1'b1;
        c.fmt      = IMM_I;
        we_raw     = 1'b1;
      end
      OPC_BRANCH: begin
        c.rs1_used = 1'b1;
        c.rs2_used = 1'b1;
        c.fmt      = IMM_B;
      end
      OPC_STORE: begin
        c.rs1_used = 1'b1;
        c.rs2_used = 1'b1;
        c.fmt      = IMM_S;
      end
      OPC_OP: begin
        c.rs1_used = 1'b1;
        c.rs2_used = 1'b1;
        we_raw     = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        c.rs1_used = 1'b1;
        c.fmt      = IMM_I;
      end
      default: begin
        c.illegal = 1'b1;
      end
    endcase
    c.rd_we = we_raw && (rd != 5'd0);
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator: instruction word plus format in,
// sign-extended 32-bit immediate out. Usable by any stage that decodes.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // Reassemble the immediate bits for the requested format.
  // NOTE: every output of a combinational block gets a default first so a
  // missing case arm can never infer a latch.
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes one instruction per cycle, reads and bypasses
// operands, blocks on RAW/WAW hazards against a destination scoreboard and
// holds the result in a single output register for execute.
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_PC_OUT = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_illegal
);

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  dec_ctrl_t   dec;
  logic [31:0] imm;

  logic [31:0] wb_clr;
  logic [31:0] sb_live;
  logic        hazard;
  logic        transfer;
  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;

  logic        ex_valid_q, ex_valid_d;
  ex_reg_t     ex_q, ex_d;
  logic [31:0] sb_q, sb_d;

  assign rs1      = if_instr[19:15];
  assign rs2      = if_instr[24:20];
  assign rd       = if_instr[11:7];
  assign rs1_addr = rs1;
  assign rs2_addr = rs2;

  // Control summary for the presented instruction.
  always_comb begin
    dec = decode_ctrl(if_instr[6:0], rd);
  end

  imm_gen u_imm_gen (
    .instr (if_instr),
    .fmt   (dec.fmt),
    .imm   (imm)
  );

  // One-hot of the scoreboard bit a writeback retires this cycle (never x0).
  always_comb begin
    wb_clr = '0;
    if (wb_valid && (wb_rd != 5'd0)) wb_clr[wb_rd] = 1'b1;
  end

  // A same-cycle writeback already resolves its register, so hazards are
  // judged against the scoreboard with that bit removed.
  assign sb_live = sb_q & ~wb_clr;
  assign hazard  = (dec.rs1_used && (rs1 != 5'd0) && sb_live[rs1]) ||
                   (dec.rs2_used && (rs2 != 5'd0) && sb_live[rs2]) ||
                   (dec.rd_we && sb_live[rd]);

  assign if_ready = !rst && !flush && !hazard && (!ex_valid_q || ex_ready);
  assign transfer = if_valid && if_ready;

  // Operand capture with bypass of the value being written back right now.
  always_comb begin
    rs1_fwd = rs1_data;
    rs2_fwd = rs2_data;
    if (wb_valid && (wb_rd == rs1) && (rs1 != 5'd0)) rs1_fwd = wb_data;
    if (wb_valid && (wb_rd == rs2) && (rs2 != 5'd0)) rs2_fwd = wb_data;
  end

  // Next state of the output register and its valid bit.
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (transfer) begin
      ex_valid_d       = 1'b1;
      ex_d.pc          = if_pc;
      ex_d.rs1_val     = rs1_fwd;
      ex_d.rs2_val     = rs2_fwd;
      ex_d.imm         = imm;
      ex_d.rd          = rd;
      ex_d.rd_we       = dec.rd_we;
      ex_d.opcode      = if_instr[6:0];
      ex_d.funct3      = if_instr[14:12];
      ex_d.funct7b5    = if_instr[30];
      ex_d.illegal     = dec.illegal;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // Scoreboard update: retire, squash, then set, so a set wins on collision.
  always_comb begin
    sb_d = sb_q & ~wb_clr;
    if (flush && ex_valid_q && ex_q.rd_we) sb_d[ex_q.rd] = 1'b0;
    if (transfer && dec.rd_we) sb_d[rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of block evaluation order.
  // NOTE: the output register data is reset as well because execute sees
  // defined zeros (and RESET_PC_OUT) while ex_valid is low out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '{pc: RESET_PC_OUT, default: '0};
      sb_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
      sb_q       <= sb_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1_val  = ex_q.rs1_val;
  assign ex_rs2_val  = ex_q.rs2_val;
  assign ex_imm      = ex_q.imm;
  assign ex_rd       = ex_q.rd;
  assign ex_rd_we    = ex_q.rd_we;
  assign ex_opcode   = ex_q.opcode;
  assign ex_funct3   = ex_q.funct3;
  assign ex_funct7b5 = ex_q.funct7b5;
  assign ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by
// randomized traffic compared against a behavioural pipeline model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_illegal;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .RESET_PC_OUT(32'h0)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_illegal(ex_illegal)
  );

  // Register file seen by the stage; x0 stays zero.
  logic [31:0] rf [32];
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F,
                         OP_JALR = 7'h67, OP_BR = 7'h63, OP_LD = 7'h03,
                         OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33,
                         OP_FENCE = 7'h0F, OP_SYS = 7'h73;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_rd;
  bit          m_we, m_f7, m_ill;
  logic [6:0]  m_op;
  logic [2:0]  m_f3;
  bit [31:0]   m_sb;
  logic        g_ready;

  function automatic void spec_use(input logic [31:0] i, output bit u1, output bit u2,
                                   output bit we, output bit ill);
    logic [6:0] op;
    op  = i[6:0];
    ill = !(op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST,
                       OP_IMM, OP_REG, OP_FENCE, OP_SYS});
    u1  = !ill && !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    u2  = op inside {OP_BR, OP_ST, OP_REG};
    we  = (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_REG})
          && (i[11:7] != 5'd0);
  endfunction

  function automatic logic [31:0] spec_imm(input logic [31:0] i);
    int v;
    case (i[6:0])
      OP_LUI, OP_AUIPC: v = int'({i[31:12], 12'h000});
      OP_JAL:           v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      OP_BR:            v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      OP_ST:            v = $signed({i[31:25], i[11:7]});
      OP_JALR, OP_LD, OP_IMM, OP_FENCE, OP_SYS: v = $signed(i[31:20]);
      default:          v = 0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_rd = '0;
    m_we = 0; m_f7 = 0; m_ill = 0; m_op = '0; m_f3 = '0; m_sb = '0;
  endtask

  task automatic check_outputs();
    check("ex_valid", 32'(ex_valid), 32'(m_valid));
    check("ex_pc", ex_pc, m_pc);
    check("ex_rs1_val", ex_rs1_val, m_rs1);
    check("ex_rs2_val", ex_rs2_val, m_rs2);
    check("ex_rd", 32'(ex_rd), 32'(m_rd));
    check("ex_rd_we", 32'(ex_rd_we), 32'(m_we));
    check("ex_opcode", 32'(ex_opcode), 32'(m_op));
    check("ex_funct3", 32'(ex_funct3), 32'(m_f3));
    check("ex_funct7b5", 32'(ex_funct7b5), 32'(m_f7));
    check("ex_illegal", 32'(ex_illegal), 32'(m_ill));
    if (!m_ill) check("ex_imm", ex_imm, m_imm);
  endtask

  // One clock: drive at the falling edge, predict and check if_ready before
  // the rising edge, then check the output register at the next falling edge.
  task automatic step(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                      input bit er, input bit wv, input logic [4:0] wr,
                      input logic [31:0] wd, input bit fl);
    bit u1, u2, we, ill, haz, xfer;
    bit [31:0] live;
    logic [4:0] s1, s2, d;
    logic [31:0] o1, o2;
    if_valid = v; if_instr = instr; if_pc = pc; ex_ready = er;
    wb_valid = wv; wb_rd = wr; wb_data = wd; flush = fl;
    #1;
    spec_use(instr, u1, u2, we, ill);
    s1 = instr[19:15]; s2 = instr[24:20]; d = instr[11:7];
    live = m_sb;
    if (wv) live[wr] = 1'b0;
    haz = (u1 && s1 != 0 && live[s1]) || (u2 && s2 != 0 && live[s2]) || (we && live[d]);
    g_ready = if_ready;
    check("if_ready", 32'(if_ready), 32'(!fl && !haz && (!m_valid || er)));
    check("rs1_addr", 32'(rs1_addr), 32'(s1));
    check("rs2_addr", 32'(rs2_addr), 32'(s2));
    xfer = v && !fl && !haz && (!m_valid || er);
    o1 = (wv && wr == s1 && s1 != 0) ? wd : rf[s1];
    o2 = (wv && wr == s2 && s2 != 0) ? wd : rf[s2];
    if (wv) m_sb[wr] = 1'b0;
    if (fl && m_valid && m_we) m_sb[m_rd] = 1'b0;
    if (xfer && we) m_sb[d] = 1'b1;
    m_sb[0] = 1'b0;
    if (fl) m_valid = 0;
    else if (xfer) begin
      m_valid = 1; m_pc = pc; m_rs1 = o1; m_rs2 = o2; m_imm = spec_imm(instr);
      m_rd = d; m_we = we; m_op = instr[6:0]; m_f3 = instr[14:12];
      m_f7 = instr[30]; m_ill = ill;
    end else if (er) m_valid = 0;
    @(posedge clk);
    @(negedge clk);
    if (wv && wr != 0) rf[wr] = wd;
    check_outputs();
  endtask

  task automatic idle(input bit er);
    step(0, 32'h0000_0013, 32'h0, er, 0, 5'd0, 32'h0, 0);
  endtask

  localparam logic [6:0] RND_OPS [12] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR,
                                          OP_LD, OP_ST, OP_IMM, OP_REG, OP_FENCE,
                                          OP_SYS, 7'h7F};

  initial begin
    rf[0] = '0;
    for (int k = 1; k < 32; k++) rf[k] = $urandom;
    rst = 1; if_valid = 1; if_instr = 32'h0050_0093; if_pc = '0; ex_ready = 1;
    wb_valid = 0; wb_rd = '0; wb_data = '0; flush = 0;
    model_reset();
    #1;
    check("rst_if_ready", 32'(if_ready), 32'h0);
    check("rst_ex_valid", 32'(ex_valid), 32'h0);
    check("rst_ex_pc", ex_pc, 32'h0);
    check("rst_ex_imm", ex_imm, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // addi x1,x0,5
    step(1, 32'h0050_0093, 32'h0, 1, 0, 5'd0, 32'h0, 0);
    check("addi_valid", 32'(ex_valid), 32'h1);
    check("addi_imm", ex_imm, 32'h5);
    check("addi_rd", 32'(ex_rd), 32'h1);
    check("addi_we", 32'(ex_rd_we), 32'h1);
    // add x2,x1,x1 stalls on x1 until its writeback
    step(1, 32'h0010_8133, 32'h4, 1, 0, 5'd0, 32'h0, 0);
    check("raw_stall", 32'(g_ready), 32'h0);
    step(1, 32'h0010_8133, 32'h4, 1, 1, 5'd1, 32'h1234, 0);
    check("raw_release", 32'(g_ready), 32'h1);
    check("bypass_rs1", ex_rs1_val, 32'h1234);
    check("bypass_rs2", ex_rs2_val, 32'h1234);
    // backpressure with addi x3,x0,1 waiting
    for (int k = 0; k < 3; k++) begin
      step(1, 32'h0010_0193, 32'h8, 0, 0, 5'd0, 32'h0, 0);
      check("bp_ready", 32'(g_ready), 32'h0);
      check("bp_pc_hold", ex_pc, 32'h4);
    end
    step(1, 32'h0010_0193, 32'h8, 1, 0, 5'd0, 32'h0, 0);
    check("bp_load_rd", 32'(ex_rd), 32'h3);
    // immediates
    step(1, 32'hFE51_2E23, 32'hC, 1, 1, 5'd2, 32'hAAAA_0000, 0);
    check("sw_imm", ex_imm, 32'hFFFF_FFFC);
    check("sw_we", 32'(ex_rd_we), 32'h0);
    step(1, 32'hFE00_0CE3, 32'h10, 1, 0, 5'd0, 32'h0, 0);
    check("beq_imm", ex_imm, 32'hFFFF_FFF8);
    step(1, 32'hABCD_E1B7, 32'h14, 1, 1, 5'd3, 32'h3, 0);
    check("lui_imm", ex_imm, 32'hABCD_E000);
    step(1, 32'h0010_00EF, 32'h18, 1, 0, 5'd0, 32'h0, 0);
    check("jal_imm", ex_imm, 32'h0000_0800);
    // flush of held addi x7
    step(1, 32'h0010_0393, 32'h1C, 1, 0, 5'd0, 32'h0, 0);
    step(1, 32'h0010_0413, 32'h20, 0, 0, 5'd0, 32'h0, 1);
    check("flush_ready", 32'(g_ready), 32'h0);
    check("flush_valid", 32'(ex_valid), 32'h0);
    step(1, 32'h0003_84B3, 32'h24, 1, 0, 5'd0, 32'h0, 0);
    check("flush_sb7_clear", 32'(g_ready), 32'h1);
    // edge cases
    step(1, 32'h0000_02FF, 32'h28, 1, 0, 5'd0, 32'h0, 0);
    check("illegal", 32'(ex_illegal), 32'h1);
    check("illegal_we", 32'(ex_rd_we), 32'h0);
    step(1, 32'h0000_0013, 32'h2C, 1, 0, 5'd0, 32'h0, 0);
    check("nop_we", 32'(ex_rd_we), 32'h0);
    step(1, 32'h0010_0213, 32'h30, 1, 1, 5'd4, 32'h44, 0);
    step(1, 32'h0002_02B3, 32'h34, 1, 0, 5'd0, 32'h0, 0);
    check("set_wins_stall", 32'(g_ready), 32'h0);
    step(1, 32'h0002_02B3, 32'h34, 1, 1, 5'd4, 32'h55, 0);
    check("set_wins_release", 32'(g_ready), 32'h1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ins;
      logic [4:0]  wr;
      bit          wv;
      ins       = $urandom;
      ins[6:0]  = RND_OPS[$urandom_range(0, 11)];
      ins[11:7] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      wv = ($urandom_range(0, 9) < 4);
      wr = 5'($urandom_range(0, 7));
      if (wv && m_sb != 0 && $urandom_range(0, 3) != 0) begin
        int s;
        s = $urandom_range(0, 31);
        for (int k = 0; k < 32; k++) begin
          if (m_sb[(s + k) % 32]) begin
            wr = 5'((s + k) % 32);
            break;
          end
        end
      end
      step($urandom_range(0, 9) < 8, ins, $urandom, $urandom_range(0, 9) < 7,
           wv, wr, $urandom, $urandom_range(0, 19) == 0);
      if (n == 700) begin
        // asynchronous reset mid-cycle clears everything immediately
        #2 rst = 1;
        #1;
        check("async_rst_valid", 32'(ex_valid), 32'h0);
        check("async_rst_ready", 32'(if_ready), 32'h0);
        check("async_rst_pc", ex_pc, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 0;
      end
    end
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
